tss_maxreduce: RTL and testbench

Streaming reduction stage that folds a sequence of 32-bit wrapping timestamps into one wrap-aware maximum per group. It applies the same comparison rule as the pairwise timestamp-max stage. It sits directly downstream of the per-channel timestamp sources: groups are delimited by `in_last`, by `flush`, or by a count limit. It emits the group maximum and the group size over a valid/ready handshake to the scheduling logic.

---
 rtl/tss_maxreduce.sv | 106 ++++++++++
 tb/tb_tss_maxreduce.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tss_maxreduce.sv
// rtl/tss_maxreduce.sv - folds a stream of wrapping 32-bit timestamps into one wrap-aware max per group
module tss_maxreduce #(
    parameter int CNT_W  = 8,
    parameter int MAXCNT = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_time,
    input  logic             in_last,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       acc_max;
    logic [CNT_W-1:0]  acc_cnt;
    logic              accept;
    logic              close;
    logic              load_fold;
    logic              load_acc;
    logic [31:0]       fold_max;
    logic [CNT_W-1:0]  fold_cnt;

    // Serial-number style compare: valid while operands lie within 2^31 of each other.
    function automatic logic ts_less(input logic [31:0] a, input logic [31:0] b);
        return (a[31] != b[31]) ^ (a[30:0] < b[30:0]);
    endfunction

    assign in_ready = reset_l && !out_valid;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state;
        fold_max   = in_time;
        fold_cnt   = CNT_W'(1);
        close      = 1'b0;
        load_fold  = 1'b0;
        load_acc   = 1'b0;
        if (state == ACC) begin
            fold_max = ts_less(acc_max, in_time) ? in_time : acc_max;
            fold_cnt = acc_cnt + CNT_W'(1);
        end
        close = accept && (in_last || flush || (fold_cnt == CNT_W'(MAXCNT)));
        case (state)
            IDLE: begin
                if (accept) begin
                    load_fold  = 1'b1;
                    state_next = close ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    load_fold = 1'b1;
                    if (close) state_next = HOLD;
                end else if (flush) begin
                    load_acc   = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            out_valid <= 1'b0;
            out_max   <= '0;
            out_count <= '0;
            acc_max   <= '0;
            acc_cnt   <= '0;
        end else begin
            out_valid <= (state_next == HOLD);
            if (load_fold) begin
                if (close) begin
                    out_max   <= fold_max;
                    out_count <= fold_cnt;
                    acc_cnt   <= '0;
                end else begin
                    acc_max <= fold_max;
                    acc_cnt <= fold_cnt;
                end
            end else if (load_acc) begin
                out_max   <= acc_max;
                out_count <= acc_cnt;
                acc_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tss_maxreduce.sv
// tb/tb_tss_maxreduce.sv - directed self-checking bench for tss_maxreduce
module tb_tss_maxreduce;

    localparam int CNT_W  = 8;
    localparam int MAXCNT = 4;

    logic             clk = 1'b0;
    logic             reset_l;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_time;
    logic             in_last;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_max;
    logic [CNT_W-1:0] out_count;

    int n_chk  = 0;
    int n_pass = 0;

    tss_maxreduce #(.CNT_W(CNT_W), .MAXCNT(MAXCNT)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_time   (in_time),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge; presents one beat for one rising edge, returns at the next negedge.
    task automatic beat(input logic [31:0] t, input logic last, input logic fl);
        in_valid = 1'b1;
        in_time  = t;
        in_last  = last;
        flush    = fl;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [31:0] exp_max, input logic [31:0] exp_cnt);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_max"},   out_max,         exp_max);
        check({tag, "_count"}, 32'(out_count), exp_cnt);
        check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop"},  32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset_l   = 1'b0;
        in_valid  = 1'b0;
        in_time   = '0;
        in_last   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_max",   out_max,         32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd0);
        reset_l = 1'b1;
        #1;
        check("rst_ready_rel", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Wrap across bit 31
        beat(32'h7FFF_FFF0, 1'b0, 1'b0);
        check("wrap1_mid", 32'(out_valid), 32'd0);
        beat(32'h8000_0010, 1'b1, 1'b0);
        pop("wrap1", 32'h8000_0010, 32'd2);

        // Wrap through zero
        beat(32'hFFFF_FFF0, 1'b0, 1'b0);
        beat(32'h0000_0005, 1'b0, 1'b0);
        beat(32'hFFFF_FF00, 1'b1, 1'b0);
        pop("wrap2", 32'h0000_0005, 32'd3);

        beat(32'h1234, 1'b1, 1'b0);
        pop("single", 32'h1234, 32'd1);

        beat(32'h50, 1'b0, 1'b0);
        beat(32'h50, 1'b1, 1'b0);
        pop("tie", 32'h50, 32'd2);

        // Backpressure with traffic offered that must be ignored
        beat(32'h77, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_time  = 32'hFFFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            flush = (i % 2 == 0);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready),  32'd0);
            check("bp_max",   out_max,         32'h77);
            check("bp_count", 32'(out_count), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
        pop("bp", 32'h77, 32'd1);

        // Flush alone closes an open group
        beat(32'h10, 1'b0, 1'b0);
        beat(32'h30, 1'b0, 1'b0);
        flush_only();
        pop("flush_alone", 32'h30, 32'd2);

        // Flush together with a beat folds the beat first
        beat(32'h10, 1'b0, 1'b0);
        beat(32'h30, 1'b0, 1'b0);
        beat(32'h40, 1'b0, 1'b1);
        pop("flush_beat", 32'h40, 32'd3);

        // Flush in IDLE does nothing
        flush_only();
        check("flush_idle", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("flush_idle2", 32'(out_valid), 32'd0);

        // Count limit at MAXCNT=4
        for (int i = 1; i <= 3; i++) begin
            beat(32'(i), 1'b0, 1'b0);
            check("cnt_mid", 32'(out_valid), 32'd0);
        end
        beat(32'h4, 1'b0, 1'b0);
        pop("cnt_lim", 32'h4, 32'd4);
        beat(32'h5, 1'b0, 1'b0);
        beat(32'h6, 1'b0, 1'b0);
        check("cnt_next_open", 32'(out_valid), 32'd0);
        flush_only();
        pop("cnt_next", 32'h6, 32'd2);

        // Reset mid-group discards the accumulation
        beat(32'h300, 1'b0, 1'b0);
        beat(32'h200, 1'b0, 1'b0);
        beat(32'h100, 1'b0, 1'b0);
        reset_l = 1'b0;
        @(negedge clk);
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_max",   out_max,         32'd0);
        check("rstmid_count", 32'(out_count), 32'd0);
        reset_l = 1'b1;
        beat(32'h9, 1'b1, 1'b0);
        pop("rstmid_next", 32'h9, 32'd1);

        // Reset in HOLD
        beat(32'h55, 1'b1, 1'b0);
        check("rsthold_pre", 32'(out_valid), 32'd1);
        reset_l = 1'b0;
        @(negedge clk);
        check("rsthold_valid", 32'(out_valid), 32'd0);
        check("rsthold_max",   out_max,         32'd0);
        reset_l = 1'b1;
        @(negedge clk);
        check("rsthold_after", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
